// File: rtl/axis_sim_pkg.sv
// Shared definitions for the AXI-Stream traffic generator: FSM encoding, length defaults
// and the last-beat byte-enable mapping.
package axis_sim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StIfg,
    StDone
  } state_e;

  localparam int unsigned MinLenDefault = 60;
  localparam int unsigned MaxLenDefault = 9600;
  localparam int unsigned LenW          = 14;

  // Low-contiguous byte enables for the residue of a length; a whole beat gives all ones.
  function automatic logic [7:0] len_to_keep(logic [2:0] rem);
    logic [7:0] keep;
    keep = 8'hFF;
    if (rem != 3'd0) begin
      keep = 8'hFF >> (4'd8 - {1'b0, rem});
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_tx_beat_fmt.sv
// Combinational beat formatter: builds one 64-bit counting-pattern beat from the frame
// index, the byte offset of the beat and the bytes still to send in the frame.
module axis_tx_beat_fmt
  import axis_sim_pkg::*;
(
  input  logic [7:0]      frame_idx_i,
  input  logic [LenW-1:0] byte_off_i,
  input  logic [LenW-1:0] bytes_left_i,
  output logic [63:0]     tdata_o,
  output logic [7:0]      tkeep_o,
  output logic            tlast_o
);

  always_comb begin
    tlast_o = (bytes_left_i <= LenW'(8));
    tkeep_o = tlast_o ? len_to_keep(bytes_left_i[2:0]) : 8'hFF;
    tdata_o = '0;
    for (int k = 0; k < 8; k++) begin
      if (tkeep_o[k]) begin
        tdata_o[8*k +: 8] = frame_idx_i + byte_off_i[7:0] + 8'(k);
      end
    end
  end

endmodule

// File: rtl/axis_tx_gen.sv
// AXI-Stream TX traffic generator: emits runs of counting-pattern frames toward a MAC.
// Build option: define AXIS_TX_GEN_ABORT_EN to flag every Nth frame as aborted via tuser.
module axis_tx_gen
  import axis_sim_pkg::*;
#(
  parameter int unsigned MIN_LEN = MinLenDefault,
  parameter int unsigned MAX_LEN = MaxLenDefault
) (
  input  logic        clk,
  input  logic        tx_axis_aresetn,
  input  logic        start,
  input  logic [13:0] pkt_len,
  input  logic [31:0] pkt_count,
  input  logic [7:0]  ifg_cycles,
  input  logic [7:0]  abort_every,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  input  logic        tx_axis_tready,
  output logic        input_pkts_done,
  output logic [63:0] pushed_pkts,
  output logic [63:0] aborted_pkts
);

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] off_q, off_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     frame_q, frame_d;
  logic [7:0]      ifg_q, ifg_d;
  logic [7:0]      ifg_cnt_q, ifg_cnt_d;
  logic [63:0]     pushed_q, pushed_d;
  logic [63:0]     aborted_q, aborted_d;

  logic [LenW-1:0] len_clamped;
  logic [LenW-1:0] bytes_left;
  logic [63:0]     fmt_data;
  logic [7:0]      fmt_keep;
  logic            fmt_last;
  logic            beat_valid;
  logic            frame_abort;
  logic            tuser_w;

`ifdef AXIS_TX_GEN_ABORT_EN
  logic [7:0] abort_every_q, abort_every_d;
  // Tracks the 1-based frame number modulo abort_every, kept in the range 1..abort_every.
  logic [7:0] abort_cnt_q, abort_cnt_d;

  assign frame_abort = (abort_every_q != 8'd0) && (abort_cnt_q == abort_every_q);
`else
  logic unused_abort_every;

  assign unused_abort_every = ^abort_every;
  assign frame_abort        = 1'b0;
`endif

  always_comb begin
    len_clamped = pkt_len;
    if (pkt_len < LenW'(MIN_LEN)) begin
      len_clamped = LenW'(MIN_LEN);
    end else if (pkt_len > LenW'(MAX_LEN)) begin
      len_clamped = LenW'(MAX_LEN);
    end
  end

  assign bytes_left = len_q - off_q;
  assign beat_valid = (state_q == StData);
  assign tuser_w    = beat_valid & fmt_last & frame_abort;

  axis_tx_beat_fmt u_beat_fmt (
    .frame_idx_i  (frame_q[7:0]),
    .byte_off_i   (off_q),
    .bytes_left_i (bytes_left),
    .tdata_o      (fmt_data),
    .tkeep_o      (fmt_keep),
    .tlast_o      (fmt_last)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    off_d     = off_q;
    count_d   = count_q;
    frame_d   = frame_q;
    ifg_d     = ifg_q;
    ifg_cnt_d = ifg_cnt_q;
    pushed_d  = pushed_q;
    aborted_d = aborted_q;
`ifdef AXIS_TX_GEN_ABORT_EN
    abort_every_d = abort_every_q;
    abort_cnt_d   = abort_cnt_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d     = len_clamped;
          count_d   = pkt_count;
          ifg_d     = ifg_cycles;
          frame_d   = 32'd1;
          off_d     = '0;
          ifg_cnt_d = '0;
          pushed_d  = '0;
          aborted_d = '0;
`ifdef AXIS_TX_GEN_ABORT_EN
          abort_every_d = abort_every;
          abort_cnt_d   = 8'd1;
`endif
          state_d = (pkt_count == 32'd0) ? StDone : StData;
        end
      end

      StData: begin
        if (tx_axis_tready) begin
          if (fmt_last) begin
            pushed_d = pushed_q + 64'd1;
            if (tuser_w) begin
              aborted_d = aborted_q + 64'd1;
            end
            off_d = '0;
            if (frame_q == count_q) begin
              state_d = StDone;
            end else begin
              frame_d = frame_q + 32'd1;
`ifdef AXIS_TX_GEN_ABORT_EN
              abort_cnt_d = (abort_cnt_q == abort_every_q) ? 8'd1 : abort_cnt_q + 8'd1;
`endif
              // Zero gap goes straight into the next frame on the following cycle.
              if (ifg_q != 8'd0) begin
                state_d   = StIfg;
                ifg_cnt_d = 8'd1;
              end
            end
          end else begin
            off_d = off_q + LenW'(8);
          end
        end
      end

      StIfg: begin
        if (ifg_cnt_q == ifg_q) begin
          state_d = StData;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state_q   <= StIdle;
      len_q     <= '0;
      off_q     <= '0;
      count_q   <= '0;
      frame_q   <= '0;
      ifg_q     <= '0;
      ifg_cnt_q <= '0;
      pushed_q  <= '0;
      aborted_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      off_q     <= off_d;
      count_q   <= count_d;
      frame_q   <= frame_d;
      ifg_q     <= ifg_d;
      ifg_cnt_q <= ifg_cnt_d;
      pushed_q  <= pushed_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef AXIS_TX_GEN_ABORT_EN
  always_ff @(posedge clk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      abort_every_q <= '0;
      abort_cnt_q   <= '0;
    end else begin
      abort_every_q <= abort_every_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end
`endif

  // Outputs decode straight from state so reset silences the stream in the same cycle.
  assign tx_axis_tvalid  = beat_valid;
  assign tx_axis_tdata   = beat_valid ? fmt_data : 64'd0;
  assign tx_axis_tkeep   = beat_valid ? fmt_keep : 8'd0;
  assign tx_axis_tlast   = beat_valid & fmt_last;
  assign tx_axis_tuser   = tuser_w;
  assign input_pkts_done = (state_q == StDone);
  assign pushed_pkts     = pushed_q;
  assign aborted_pkts    = aborted_q;

endmodule
